// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer, hazard detector and datapath.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        MDIV_WAIT = 1'b1
    } stall_state_t;

    localparam int unsigned MDIV_MAX_CYCLES_DEF = 40;
    localparam int unsigned CNT_W_DEF           = 32;

    // Hazard priority, 0 = highest; hazard detector and datapath resolve in the same order.
    localparam int unsigned PRIO_MULDIV   = 0;
    localparam int unsigned PRIO_BRANCH   = 1;
    localparam int unsigned PRIO_LOAD_USE = 2;

endpackage

// File: rtl/stall_perf_counter.sv
// Wrapping event counter with synchronous clear, used for stall/flush statistics.
module stall_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, branch redirect and mul/div busy with a watchdog.
// Optional perf counters built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MDIV_MAX_CYCLES = MDIV_MAX_CYCLES_DEF
`ifdef STALL_PERF_CNT_EN
    , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_use_stall,
    input  logic branch_taken_ex,
    input  logic muldiv_start,
    input  logic muldiv_done,
    output logic pc_we,
    output logic if_id_we,
    output logic if_id_flush,
    output logic id_ex_we,
    output logic id_ex_flush,
    output logic ex_mem_flush,
    output logic muldiv_abort,
    output logic muldiv_err
`ifdef STALL_PERF_CNT_EN
    , output logic [CNT_W-1:0] perf_stall_cnt
    , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    localparam int unsigned     WD_W    = $clog2(MDIV_MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDIV_MAX_CYCLES - 1);

    stall_state_t    r_state, w_state_nxt;
    logic [WD_W-1:0] r_wd_cnt, w_wd_nxt;
    logic            r_err, w_err_nxt;

    logic w_pc_we, w_if_id_we, w_id_ex_we;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wd_cnt <= w_wd_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wd_nxt       = r_wd_cnt;
        w_err_nxt      = r_err;
        w_pc_we        = 1'b1;
        w_if_id_we     = 1'b1;
        w_id_ex_we     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            RUN: begin
                // start together with done is a single-cycle op and needs no stall
                if (muldiv_start && !muldiv_done) begin
                    w_pc_we        = 1'b0;
                    w_if_id_we     = 1'b0;
                    w_id_ex_we     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                    w_state_nxt    = MDIV_WAIT;
                    w_wd_nxt       = WD_W'(1);
                end else if (branch_taken_ex) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (load_use_stall) begin
                    w_pc_we       = 1'b0;
                    w_if_id_we    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end
            end
            MDIV_WAIT: begin
                w_pc_we        = 1'b0;
                w_if_id_we     = 1'b0;
                w_id_ex_we     = 1'b0;
                w_ex_mem_flush = 1'b1;
                if (muldiv_done) begin
                    w_ex_mem_flush = 1'b0;
                    w_state_nxt    = RUN;
                end else if (r_wd_cnt >= WD_LAST) begin
                    w_abort     = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RUN;
                end else if (r_wd_cnt != '1) begin
                    w_wd_nxt = r_wd_cnt + WD_W'(1);
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Reset forces every enable/flush low without waiting for a clock.
    assign pc_we        = rst_n & w_pc_we;
    assign if_id_we     = rst_n & w_if_id_we;
    assign id_ex_we     = rst_n & w_id_ex_we;
    assign if_id_flush  = rst_n & w_if_id_flush;
    assign id_ex_flush  = rst_n & w_id_ex_flush;
    assign ex_mem_flush = rst_n & w_ex_mem_flush;
    assign muldiv_abort = rst_n & w_abort;
    assign muldiv_err   = r_err;

`ifdef STALL_PERF_CNT_EN
    stall_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (~pc_we),
        .i_clr (1'b0),
        .o_cnt (perf_stall_cnt)
    );

    stall_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (if_id_flush),
        .i_clr (1'b0),
        .o_cnt (perf_flush_cnt)
    );
`endif

endmodule
